// File: rtl/makehint_pack_pkg.sv
// Shared ML-DSA constants and FSM state encoding for the hint packer.
package makehint_pack_pkg;

  localparam int MLDSA_K         = 8;
  localparam int MLDSA_OMEGA     = 75;
  localparam int COEFFS_PER_WORD = 4;
  localparam int WORDS_PER_POLY  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COUNT,
    ST_FILL,
    ST_DONE
  } mhp_state_e;

endpackage

// File: rtl/makehint_pack.sv
// HintBitPack: scans the z-bit buffer one coefficient per cycle and writes
// hint indices, per-poly cumulative counts and zero fill into the hint buffer.
module makehint_pack
  import makehint_pack_pkg::*;
#(
  parameter int K           = MLDSA_K,
  parameter int OMEGA       = MLDSA_OMEGA,
  parameter int MEM_ADDR_W  = 9,
  parameter int MEM_DATA_W  = 4,
  parameter int HINT_ADDR_W = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   zeroize,
  input  logic                   start,
  output logic                   mem_rden,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  input  logic [MEM_DATA_W-1:0]  mem_rdata,
  output logic                   hint_wren,
  output logic [HINT_ADDR_W-1:0] hint_addr,
  output logic [7:0]             hint_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   invalid
);

  localparam int POLY_W = $clog2(K);
  localparam int WORD_W = $clog2(WORDS_PER_POLY);
  localparam int BIT_W  = $clog2(COEFFS_PER_WORD);

  localparam logic [HINT_ADDR_W-1:0] OMEGA_C     = HINT_ADDR_W'(OMEGA);
  localparam logic [HINT_ADDR_W-1:0] OMEGA_M1_C  = HINT_ADDR_W'(OMEGA - 1);
  localparam logic [POLY_W-1:0]      LAST_POLY_C = POLY_W'(K - 1);
  localparam logic [WORD_W-1:0]      LAST_WORD_C = WORD_W'(WORDS_PER_POLY - 1);
  localparam logic [BIT_W-1:0]       LAST_BIT_C  = BIT_W'(COEFFS_PER_WORD - 1);

  mhp_state_e             state_q, state_d;
  logic [HINT_ADDR_W-1:0] idx_q, idx_d;
  logic [POLY_W-1:0]      poly_q, poly_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   invalid_q, invalid_d;

  logic [WORD_W-1:0]      word_inc;
  logic [POLY_W-1:0]      poly_inc;
  logic                   hint_bit;

  assign word_inc = word_q + WORD_W'(1);
  assign poly_inc = poly_q + POLY_W'(1);
  assign hint_bit = mem_rdata[bit_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poly_d     = poly_q;
    word_d     = word_q;
    bit_d      = bit_q;
    invalid_d  = invalid_q;
    mem_rden   = 1'b0;
    mem_addr   = '0;
    hint_wren  = 1'b0;
    hint_addr  = '0;
    hint_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mem_rden  = 1'b1;
          idx_d     = '0;
          poly_d    = '0;
          word_d    = '0;
          bit_d     = '0;
          invalid_d = 1'b0;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (hint_bit && (idx_q == OMEGA_C)) begin
          // One hint too many: abandon the scan, signature must be rejected
          invalid_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          if (hint_bit) begin
            hint_wren  = 1'b1;
            hint_addr  = idx_q;
            hint_wdata = 8'({word_q, bit_q});
            idx_d      = idx_q + HINT_ADDR_W'(1);
          end
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT_C) begin
            if (word_q != LAST_WORD_C) begin
              mem_rden = 1'b1;
              mem_addr = MEM_ADDR_W'({poly_q, word_inc});
              word_d   = word_inc;
            end else begin
              state_d = ST_COUNT;
            end
          end
        end
      end

      ST_COUNT: begin
        hint_wren  = 1'b1;
        hint_addr  = OMEGA_C + HINT_ADDR_W'(poly_q);
        hint_wdata = 8'(idx_q);
        if (poly_q != LAST_POLY_C) begin
          mem_rden = 1'b1;
          mem_addr = MEM_ADDR_W'({poly_inc, {WORD_W{1'b0}}});
          poly_d   = poly_inc;
          word_d   = '0;
          bit_d    = '0;
          state_d  = ST_SCAN;
        end else if (idx_q == OMEGA_C) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        hint_wren  = 1'b1;
        hint_addr  = idx_q;
        hint_wdata = '0;
        idx_d      = idx_q + HINT_ADDR_W'(1);
        if (idx_q == OMEGA_M1_C) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Zeroize suppresses every strobe in the cycle it is seen
    if (zeroize) begin
      mem_rden   = 1'b0;
      mem_addr   = '0;
      hint_wren  = 1'b0;
      hint_addr  = '0;
      hint_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      poly_q    <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      invalid_q <= 1'b0;
    end else if (zeroize) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      poly_q    <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      poly_q    <= poly_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == ST_SCAN) || (state_q == ST_COUNT) || (state_q == ST_FILL);
  assign done    = (state_q == ST_DONE);
  assign invalid = invalid_q;

endmodule

// File: tb/tb_makehint_pack.sv
// Scoreboard bench for makehint_pack: a reference packer fills an expected
// write queue from the z-buffer image; DUT hint writes are popped and compared.
module tb_makehint_pack;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       zeroize;
  logic       start;
  logic       mem_rden;
  logic [8:0] mem_addr;
  logic [3:0] mem_rdata = '0;
  logic       hint_wren;
  logic [6:0] hint_addr;
  logic [7:0] hint_wdata;
  logic       busy;
  logic       done;
  logic       invalid;

  logic [3:0] zmem [512];

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  makehint_pack dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .start      (start),
    .mem_rden   (mem_rden),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .hint_wren  (hint_wren),
    .hint_addr  (hint_addr),
    .hint_wdata (hint_wdata),
    .busy       (busy),
    .done       (done),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  // z-buffer: registered read, data holds while mem_rden is low
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= zmem[mem_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) zmem[i] = 4'h0;
  endtask

  // Reference HintBitPack: expected writes, done cycle and invalid flag
  task automatic build_expect(output int exp_done, output bit exp_inv);
    int   cnt;
    logic [3:0] wd;
    wr_t  w;
    exp_q.delete();
    cnt      = 0;
    exp_inv  = 1'b0;
    exp_done = -1;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 64; a++) begin
        wd = zmem[p*64 + a];
        for (int b = 0; b < 4; b++) begin
          if (wd[b]) begin
            if (cnt < 75) begin
              w.addr = cnt;
              w.data = a*4 + b;
              exp_q.push_back(w);
              cnt++;
            end else begin
              exp_inv  = 1'b1;
              exp_done = 1 + 257*p + 4*a + b + 1;
              return;
            end
          end
        end
      end
      w.addr = 75 + p;
      w.data = cnt;
      exp_q.push_back(w);
    end
    for (int i = cnt; i < 75; i++) begin
      w.addr = i;
      w.data = 0;
      exp_q.push_back(w);
    end
    exp_done = 2056 + (75 - cnt) + 1;
  endtask

  task automatic run_pack(input string name);
    int   exp_done;
    bit   exp_inv;
    int   cyc;
    int   nwr;
    bit   seen;
    logic prev_rden;
    wr_t  w;
    build_expect(exp_done, exp_inv);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check({name, " start_rden"}, int'(mem_rden), 1);
    check({name, " start_addr"}, int'(mem_addr), 0);
    prev_rden = mem_rden;
    @(posedge clk); #1 start = 1'b0;
    cyc  = 0;
    nwr  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({name, " busy_c1"}, int'(busy), 1);
        check({name, " inv_clear"}, int'(invalid), 0);
      end
      check({name, " rden_b2b"}, int'(mem_rden && prev_rden), 0);
      prev_rden = mem_rden;
      if (hint_wren) begin
        nwr++;
        if (exp_q.size() == 0) begin
          check({name, " extra_write_addr"}, int'(hint_addr), -1);
        end else begin
          w = exp_q.pop_front();
          check({name, " waddr"}, int'(hint_addr), w.addr);
          check({name, " wdata"}, int'(hint_wdata), w.data);
        end
      end
      if (done) begin
        seen = 1'b1;
        check({name, " done_cycle"}, cyc, exp_done);
        check({name, " invalid"}, int'(invalid), int'(exp_inv));
        check({name, " busy_done"}, int'(busy), 0);
        check({name, " missing_writes"}, exp_q.size(), 0);
      end
    end
    if (!seen) check({name, " done_timeout"}, 0, 1);
    $display("pack %s: %0d writes, done at cycle %0d, invalid=%0d", name, nwr, cyc, invalid);
  endtask

  initial begin
    reset_n = 1'b0;
    zeroize = 1'b0;
    start   = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst invalid", int'(invalid), 0);
    check("rst hint_wren", int'(hint_wren), 0);
    check("rst mem_rden", int'(mem_rden), 0);

    run_pack("all_zero");

    clear_mem();
    zmem[65] = 4'b0100;
    run_pack("single_bit");

    clear_mem();
    zmem[0]   = 4'hF;
    zmem[511] = 4'h8;
    run_pack("edges");

    // 31 + 31 + 13 hints = exactly OMEGA
    clear_mem();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 7; a++) zmem[p*64 + a] = 4'hF;
      zmem[p*64 + 7] = 4'b0111;
    end
    for (int a = 128; a < 131; a++) zmem[a] = 4'hF;
    zmem[131] = 4'b0001;
    run_pack("exact_omega");

    zmem[200] = 4'b0001;
    run_pack("over_omega");

    zmem[200] = 4'b0000;
    run_pack("after_invalid");

    // Abort partway through poly 3
    clear_mem();
    zmem[65] = 4'b0100;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (820) @(posedge clk);
    @(negedge clk);
    check("zz busy_before", int'(busy), 1);
    @(posedge clk); #1 zeroize = 1'b1;
    @(negedge clk);
    check("zz wren_same", int'(hint_wren), 0);
    @(posedge clk);
    @(negedge clk);
    check("zz busy", int'(busy), 0);
    check("zz done", int'(done), 0);
    check("zz invalid", int'(invalid), 0);
    check("zz hint_wren", int'(hint_wren), 0);
    check("zz mem_rden", int'(mem_rden), 0);
    check("zz hint_addr", int'(hint_addr), 0);
    @(posedge clk); #1 zeroize = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("zz idle_done", int'(done), 0);
      check("zz idle_busy", int'(busy), 0);
    end
    run_pack("after_zeroize");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/makehint_pack.md
Name: makehint_pack

Overview:
- Downstream consumer of the decompose z-bit buffer (8 polys × 64 addr × 4 bits; bit j of word a = coeff 4·(a mod 64)+j of poly a/64).
- Scans all 2048 hint bits in order and emits the ML-DSA HintBitPack byte stream into the signature hint buffer:
  - bytes 0..OMEGA-1: coefficient indices of set bits, zero-filled after the last index;
  - bytes OMEGA..OMEGA+K-1: cumulative index count after each poly.
- Flags signature rejection when more than OMEGA hints are present.

Parameters:
- K, 8: number of polynomials.
- OMEGA, 75: maximum hint count.
- MEM_ADDR_W, 9: z-buffer address width (K·64 words).
- MEM_DATA_W, 4: bits per z-buffer word.
- HINT_ADDR_W, 7: hint buffer address width (must cover OMEGA+K).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state
- start  in  1  single-cycle pulse, begin pack; ignored unless idle
- mem_rden  out  1  z-buffer read enable
- mem_addr  out  MEM_ADDR_W  z-buffer address
- mem_rdata  in  MEM_DATA_W  z-buffer read data
  - valid the cycle after mem_rden
  - holds while mem_rden is low
- hint_wren  out  1  hint buffer write strobe
- hint_addr  out  HINT_ADDR_W  hint byte address
- hint_wdata  out  8  hint byte
- busy  out  1  high from the cycle after start until the done cycle
- done  out  1  one-cycle completion pulse
- invalid  out  1  hint count exceeded OMEGA; held until next accepted start or zeroize

Behaviour:
- Reset/zeroize:
  - All outputs 0, FSM to IDLE, counters 0, invalid=0.
  - Zeroize mid-operation aborts immediately with no done pulse.
- States: IDLE, SCAN, COUNT, FILL, DONE.
- IDLE:
  - On start: mem_rden=1, mem_addr=0, clear idx_cnt/poly/word/bit counters and invalid; go to SCAN next cycle.
- SCAN (one coefficient per cycle; bit counter b=0..3 selects mem_rdata[b]):
  - If the bit is set and idx_cnt<OMEGA: hint_wren=1, hint_addr=idx_cnt, hint_wdata=8-bit index 4·word+b; idx_cnt++.
  - If the bit is set and idx_cnt==OMEGA: invalid=1, no write, go to DONE next cycle.
  - On b=3 with word<63: mem_rden=1, mem_addr=addr+1, word++, b wraps to 0. Steady state is 4 cycles per word.
  - On b=3 with word==63: go to COUNT.
- COUNT (1 cycle per poly):
  - hint_wren=1, hint_addr=OMEGA+poly, hint_wdata=idx_cnt.
  - If poly<K-1: mem_rden=1, mem_addr=(poly+1)·64; poly++; word=0; return to SCAN.
  - Otherwise: go to FILL, or to DONE if idx_cnt==OMEGA.
- FILL:
  - Each cycle: hint_wren=1, hint_addr=idx_cnt, hint_wdata=0; idx_cnt++.
  - After writing OMEGA-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timing with start at cycle 0:
  - First SCAN cycle is 1.
  - Each poly takes 256 SCAN + 1 COUNT; the last COUNT is at cycle 2056.
  - FILL takes OMEGA-n cycles for n hints; DONE follows.
- Boundaries:
  - idx_cnt saturates at OMEGA; never write above OMEGA+K-1.
  - Exactly OMEGA hints is valid (no FILL cycles).
  - Index byte is 0..255 (wraps per poly).
  - At most one hint write per cycle.
  - start while busy is ignored.
  - mem_rden is never high in two consecutive cycles.

Decomposition:
- Shared package (abr_params style):
  - constants MLDSA_K, MLDSA_OMEGA, coeffs-per-word 4, words-per-poly 64;
  - typedef enum for the states above.
- No sub-module: the FSM, counters and address generation are inline (~200 lines).

Test Plan:
- All-zero z-buffer, start:
  - 8 COUNT writes of 0 at addr 75..82, then 75 FILL writes of 0 at addr 0..74.
  - done at cycle 2132; invalid=0.
- Single bit at mem[65] bit 2 (poly 1, coeff 6):
  - byte0=6, bytes 1..74=0;
  - counts: addr 75=0, addrs 76..82=1.
- mem[0]=4'hF, mem[511]=4'h8:
  - indices 0,1,2,3,255;
  - counts 4,4,4,4,4,4,4,5;
  - FILL writes addr 5..74.
- Exactly 75 set bits spread over polys 0..2 (31+31+13):
  - no FILL writes; invalid=0;
  - counts 31,62,75,75,75,75,75,75.
- 76 set bits:
  - the 76th set bit sets invalid=1, no write occurs at addr 75, DONE follows next cycle;
  - a new start clears invalid.
- Zeroize asserted mid-SCAN of poly 3:
  - next cycle: busy=0, no done, all outputs 0;
  - a subsequent start completes normally.
